// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: sequences EX/MEM data accesses onto a split-transaction SRAM bus
module dmem_access_ctrl #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              req_valid,
    input  logic              req_wr,
    input  logic [1:0]        req_size,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              req_ready,
    output logic              stallreq,
    output logic              data_sram_req,
    output logic              data_sram_wr,
    output logic [1:0]        data_sram_size,
    output logic [ADDR_W-1:0] data_sram_addr,
    output logic [3:0]        data_sram_wstrb,
    output logic [DATA_W-1:0] data_sram_wdata,
    input  logic              data_sram_addr_ok,
    input  logic              data_sram_data_ok,
    input  logic [DATA_W-1:0] data_sram_rdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic              resp_err,
    output logic [DATA_W-1:0] resp_rdata
);
    typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;
    state_t            state_q, state_d;
    logic              drop_q, drop_d;
    logic              wr_q, wr_d;
    logic [1:0]        size_q, size_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [3:0]        wstrb_q, wstrb_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              resp_err_q, resp_err_d;
    logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
    logic              aligned;
    logic [3:0]        strb;
    logic [DATA_W-1:0] wrep;

    // decode alignment, byte enables and lane-replicated store data from the live request
    always_comb begin
        aligned = (req_size == 2'd0) || (req_size == 2'd1 && !req_addr[0]) || (req_size == 2'd2 && req_addr[1:0] == 2'b00);
        strb = !req_wr ? 4'b0000 : req_size == 2'd0 ? 4'b0001 << req_addr[1:0] : req_size == 2'd1 ? 4'b0011 << req_addr[1:0] : 4'b1111;
        wrep = req_size == 2'd0 ? {4{req_wdata[7:0]}} : req_size == 2'd1 ? {2{req_wdata[15:0]}} : req_wdata;
    end

    // next state: one outstanding access, a flushed bus access is drained via drop
    always_comb begin
        state_d = state_q;
        drop_d = drop_q;
        wr_d = wr_q;
        size_d = size_q;
        addr_d = addr_q;
        wstrb_d = wstrb_q;
        wdata_d = wdata_q;
        resp_err_d = resp_err_q;
        resp_rdata_d = resp_rdata_q;
        case (state_q)
            IDLE: if (req_valid && !flush) begin
                if (aligned) begin
                    state_d = ADDR;
                    wr_d = req_wr;
                    size_d = req_size;
                    addr_d = req_addr;
                    wstrb_d = strb;
                    wdata_d = wrep;
                end else begin
                    state_d = RESP;
                    resp_err_d = 1'b1;
                    resp_rdata_d = '0;
                end
            end
            ADDR: if (data_sram_addr_ok) begin
                state_d = DATA;
                drop_d = flush;
            end else if (flush) begin
                state_d = IDLE;
            end
            DATA: if (data_sram_data_ok) begin
                state_d = (drop_q || flush) ? IDLE : RESP;
                resp_rdata_d = (drop_q || flush) ? resp_rdata_q : wr_q ? '0 : data_sram_rdata;
                drop_d = 1'b0;
            end else if (flush) begin
                drop_d = 1'b1;
            end
            RESP: if (resp_ready || flush) begin
                state_d = IDLE;
                resp_err_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    // state and registered outputs, cleared by reset so a pending bus access is abandoned
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            drop_q <= 1'b0;
            wr_q <= 1'b0;
            size_q <= 2'd0;
            addr_q <= '0;
            wstrb_q <= 4'b0000;
            wdata_q <= '0;
            resp_err_q <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            state_q <= state_d;
            drop_q <= drop_d;
            wr_q <= wr_d;
            size_q <= size_d;
            addr_q <= addr_d;
            wstrb_q <= wstrb_d;
            wdata_q <= wdata_d;
            resp_err_q <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end

    assign req_ready = state_q == IDLE && !flush;
    assign stallreq = (state_q == IDLE && req_valid && aligned && !flush) || ((state_q == ADDR || state_q == DATA) && !drop_q) || (req_valid && !req_ready && !flush);
    assign data_sram_req = state_q == ADDR;
    assign data_sram_wr = wr_q;
    assign data_sram_size = size_q;
    assign data_sram_addr = addr_q;
    assign data_sram_wstrb = wstrb_q;
    assign data_sram_wdata = wdata_q;
    assign resp_valid = state_q == RESP;
    assign resp_err = resp_err_q;
    assign resp_rdata = resp_rdata_q;
endmodule

// File: tb/tb_dmem_access_ctrl.sv
// tb_dmem_access_ctrl: directed bench with a transaction-level reference model
module tb_dmem_access_ctrl;
    logic        clk, rst, flush, req_valid, req_wr, req_ready, stallreq;
    logic [1:0]  req_size, data_sram_size;
    logic [31:0] req_addr, req_wdata, data_sram_addr, data_sram_wdata, data_sram_rdata, resp_rdata;
    logic        data_sram_req, data_sram_wr, data_sram_addr_ok, data_sram_data_ok;
    logic [3:0]  data_sram_wstrb;
    logic        resp_valid, resp_ready, resp_err;
    int          tests = 0, fails = 0;
    logic        chk_on = 1'b0;

    dmem_access_ctrl dut (
        .clk(clk), .rst(rst), .flush(flush), .req_valid(req_valid), .req_wr(req_wr),
        .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
        .stallreq(stallreq), .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
        .data_sram_size(data_sram_size), .data_sram_addr(data_sram_addr),
        .data_sram_wstrb(data_sram_wstrb), .data_sram_wdata(data_sram_wdata),
        .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok),
        .data_sram_rdata(data_sram_rdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_err(resp_err), .resp_rdata(resp_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    function automatic bit is_aligned(input logic [1:0] sz, input logic [31:0] a);
        return sz != 2'd3 && (a % (32'd1 << sz)) == 32'd0;
    endfunction

    function automatic logic [3:0] lanes(input logic wr, input logic [1:0] sz, input logic [31:0] a);
        int n;
        n = 1 << sz;
        return wr ? 4'(((1 << n) - 1) << (a % 4)) : 4'b0000;
    endfunction

    function automatic logic [31:0] rep(input logic [1:0] sz, input logic [31:0] wd);
        logic [31:0] r;
        int n;
        n = 1 << sz;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % n) +: 8];
        return r;
    endfunction

    // model: an access is either waiting for bus accept, in flight, or a held response
    bit          m_req, m_fly, m_drop, m_resp, m_err, m_wr;
    logic [1:0]  m_size;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic [3:0]  m_strb;

    initial begin
        bit idle, e_ready, e_stall;
        wait (chk_on);
        forever begin
            @(negedge clk);
            idle = !(m_req || m_fly || m_resp);
            e_ready = idle && !flush;
            e_stall = (idle && req_valid && is_aligned(req_size, req_addr) && !flush) || m_req
                      || (m_fly && !m_drop) || (req_valid && !e_ready && !flush);
            chk("req_ready", req_ready, e_ready);
            chk("stallreq", stallreq, e_stall);
            chk("sram_req", data_sram_req, m_req);
            chk("resp_valid", resp_valid, m_resp);
            if (m_req) begin
                chk("sram_addr", data_sram_addr, m_addr);
                chk("sram_size", data_sram_size, m_size);
                chk("sram_wr", data_sram_wr, m_wr);
                chk("sram_wstrb", data_sram_wstrb, m_strb);
                if (m_wr) chk("sram_wdata", data_sram_wdata, m_wdata);
            end
            if (m_resp) begin
                chk("resp_err", resp_err, m_err);
                chk("resp_rdata", resp_rdata, m_rdata);
            end
            if (rst) begin
                {m_req, m_fly, m_drop, m_resp} = '0;
            end else if (idle) begin
                if (req_valid && !flush) begin
                    if (is_aligned(req_size, req_addr)) begin
                        m_req = 1; m_wr = req_wr; m_size = req_size; m_addr = req_addr;
                        m_strb = lanes(req_wr, req_size, req_addr);
                        m_wdata = rep(req_size, req_wdata);
                    end else begin
                        m_resp = 1; m_err = 1; m_rdata = 0;
                    end
                end
            end else if (m_req) begin
                if (data_sram_addr_ok) begin
                    m_req = 0; m_fly = 1; m_drop = flush;
                end else if (flush) m_req = 0;
            end else if (m_fly) begin
                if (data_sram_data_ok) begin
                    m_fly = 0;
                    if (!(m_drop || flush)) begin
                        m_resp = 1; m_err = 0; m_rdata = m_wr ? 32'd0 : data_sram_rdata;
                    end
                    m_drop = 0;
                end else if (flush) m_drop = 1;
            end else if (resp_ready || flush) m_resp = 0;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic peek;
        @(negedge clk);
    endtask

    task automatic set_req(input logic wr, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
        req_valid = 1; req_wr = wr; req_size = sz; req_addr = a; req_wdata = wd;
    endtask

    task automatic quiet;
        req_valid = 0; flush = 0; data_sram_addr_ok = 0; data_sram_data_ok = 0; data_sram_rdata = 0;
    endtask

    // drive accepted store through a one-cycle bus and return to phase after response
    task automatic store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] x_strb, input logic [31:0] x_wdata);
        set_req(1, sz, a, wd); tick;
        req_valid = 0; data_sram_addr_ok = 1;
        peek; chk("st_req", data_sram_req, 1); chk("st_wstrb", data_sram_wstrb, x_strb);
        chk("st_wdata", data_sram_wdata, x_wdata); tick;
        data_sram_addr_ok = 0; data_sram_data_ok = 1; data_sram_rdata = 32'h77; tick;
        quiet; peek; chk("st_resp_valid", resp_valid, 1); chk("st_resp_rdata", resp_rdata, 0); tick;
    endtask

    initial begin
        rst = 1; resp_ready = 1; req_wr = 0; req_size = 0; req_addr = 0; req_wdata = 0;
        quiet;
        tick; tick;
        rst = 0; chk_on = 1;
        peek; chk("rst_ready", req_ready, 1); chk("rst_req", data_sram_req, 0);
        chk("rst_resp_valid", resp_valid, 0); chk("rst_stall", stallreq, 0); tick;

        set_req(0, 2, 32'h100, 0);
        peek; chk("ld_stall_t0", stallreq, 1); chk("ld_req_t0", data_sram_req, 0); tick;
        req_valid = 0; data_sram_addr_ok = 1;
        peek; chk("ld_req_t1", data_sram_req, 1); chk("ld_wstrb", data_sram_wstrb, 0);
        chk("ld_addr", data_sram_addr, 32'h100); chk("ld_stall_t1", stallreq, 1); tick;
        data_sram_addr_ok = 0; data_sram_data_ok = 1; data_sram_rdata = 32'hDEADBEEF;
        peek; chk("ld_req_t2", data_sram_req, 0); chk("ld_stall_t2", stallreq, 1); tick;
        quiet;
        peek; chk("ld_valid_t3", resp_valid, 1); chk("ld_rdata_t3", resp_rdata, 32'hDEADBEEF);
        chk("ld_stall_t3", stallreq, 0); tick;
        peek; chk("ld_ready_t4", req_ready, 1); tick;

        store(0, 32'h203, 32'h000000A5, 4'b1000, 32'hA5A5A5A5);
        store(1, 32'h202, 32'h00001234, 4'b1100, 32'h12341234);

        set_req(0, 1, 32'h301, 0);
        peek; chk("mis_h_stall0", stallreq, 0); tick;
        req_valid = 0;
        peek; chk("mis_h_valid", resp_valid, 1); chk("mis_h_err", resp_err, 1);
        chk("mis_h_rdata", resp_rdata, 0); chk("mis_h_req", data_sram_req, 0); chk("mis_h_stall", stallreq, 0); tick;
        set_req(0, 2, 32'h302, 0);
        peek; chk("mis_w_stall0", stallreq, 0); tick;
        req_valid = 0;
        peek; chk("mis_w_valid", resp_valid, 1); chk("mis_w_err", resp_err, 1); chk("mis_w_req", data_sram_req, 0); tick;

        set_req(1, 2, 32'h404, 32'hCAFEF00D); tick;
        req_valid = 0;
        for (int i = 0; i < 5; i++) begin
            peek; chk("bp_req", data_sram_req, 1); chk("bp_addr", data_sram_addr, 32'h404);
            chk("bp_wstrb", data_sram_wstrb, 4'hF); chk("bp_wdata", data_sram_wdata, 32'hCAFEF00D); tick;
        end
        data_sram_addr_ok = 1; tick;
        data_sram_addr_ok = 0; data_sram_data_ok = 1; tick;
        quiet; tick;

        set_req(0, 2, 32'h500, 0); tick;
        req_valid = 0; data_sram_addr_ok = 1; tick;
        data_sram_addr_ok = 0; data_sram_data_ok = 1; data_sram_rdata = 32'h13579BDF; resp_ready = 0; tick;
        quiet; set_req(0, 2, 32'h600, 0);
        for (int i = 0; i < 3; i++) begin
            peek; chk("hold_valid", resp_valid, 1); chk("hold_rdata", resp_rdata, 32'h13579BDF);
            chk("hold_ready", req_ready, 0); chk("hold_stall", stallreq, 1); tick;
        end
        resp_ready = 1;
        peek; chk("consume_ready", req_ready, 0); tick;
        peek; chk("next_ready", req_ready, 1); chk("next_stall", stallreq, 1); chk("next_valid", resp_valid, 0); tick;
        req_valid = 0; data_sram_addr_ok = 1;
        peek; chk("next_addr", data_sram_addr, 32'h600); tick;
        data_sram_addr_ok = 0; data_sram_data_ok = 1; data_sram_rdata = 32'h2468ACE0; tick;
        quiet; peek; chk("next_rdata", resp_rdata, 32'h2468ACE0); tick;

        set_req(0, 2, 32'h700, 0); tick;
        req_valid = 0; flush = 1;
        peek; chk("fa_req", data_sram_req, 1); chk("fa_ready", req_ready, 0); tick;
        flush = 0;
        peek; chk("fa_req_after", data_sram_req, 0); chk("fa_ready_after", req_ready, 1); chk("fa_stall", stallreq, 0); tick;

        set_req(0, 2, 32'h704, 0); tick;
        req_valid = 0; data_sram_addr_ok = 1; tick;
        data_sram_addr_ok = 0; flush = 1;
        peek; chk("fd_stall_flush", stallreq, 1); tick;
        flush = 0;
        peek; chk("fd_stall_drop", stallreq, 0); chk("fd_ready", req_ready, 0); tick;
        tick;
        data_sram_data_ok = 1; data_sram_rdata = 32'h55;
        peek; chk("fd_ready_dok", req_ready, 0); tick;
        quiet;
        peek; chk("fd_valid", resp_valid, 0); chk("fd_ready_after", req_ready, 1); tick;

        set_req(0, 2, 32'h708, 0); tick;
        req_valid = 0; data_sram_addr_ok = 1; flush = 1; tick;
        quiet; tick;
        data_sram_data_ok = 1; data_sram_rdata = 32'h99; tick;
        quiet; peek; chk("fao_valid", resp_valid, 0); tick;

        set_req(0, 3, 32'h0, 0); tick;
        req_valid = 0; resp_ready = 0; flush = 1;
        peek; chk("fr_valid", resp_valid, 1); chk("fr_err", resp_err, 1); tick;
        flush = 0; resp_ready = 1;
        peek; chk("fr_valid_after", resp_valid, 0); chk("fr_err_after", resp_err, 0); tick;

        set_req(0, 2, 32'hA00, 0); flush = 1;
        peek; chk("fi_ready", req_ready, 0); chk("fi_stall", stallreq, 0); tick;
        quiet;
        peek; chk("fi_req", data_sram_req, 0); tick;

        set_req(0, 2, 32'h900, 0); tick;
        req_valid = 0; data_sram_addr_ok = 1; data_sram_data_ok = 1; data_sram_rdata = 32'hBAD; tick;
        quiet;
        peek; chk("dd_valid", resp_valid, 0); chk("dd_stall", stallreq, 1); tick;
        data_sram_data_ok = 1; data_sram_rdata = 32'h600D; tick;
        quiet; peek; chk("dd_rdata", resp_rdata, 32'h600D); tick;

        set_req(0, 2, 32'h800, 32'h11111111); tick;
        req_valid = 0; data_sram_addr_ok = 1; tick;
        data_sram_addr_ok = 0; rst = 1;
        peek; chk("rd_stall", stallreq, 1); tick;
        rst = 0;
        peek; chk("rd_ready", req_ready, 1); chk("rd_req", data_sram_req, 0); chk("rd_addr", data_sram_addr, 0);
        chk("rd_wstrb", data_sram_wstrb, 0); chk("rd_wdata", data_sram_wdata, 0); chk("rd_valid", resp_valid, 0);
        chk("rd_err", resp_err, 0); chk("rd_rdata", resp_rdata, 0); chk("rd_stall_after", stallreq, 0); tick;
        set_req(0, 2, 32'h804, 0); tick;
        req_valid = 0; data_sram_addr_ok = 1;
        peek; chk("rl_addr", data_sram_addr, 32'h804); tick;
        data_sram_addr_ok = 0; data_sram_data_ok = 1; data_sram_rdata = 32'h0BADF00D; tick;
        quiet; peek; chk("rl_valid", resp_valid, 1); chk("rl_rdata", resp_rdata, 32'h0BADF00D); tick;
        tick;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/dmem_access_ctrl.md
Name: dmem_access_ctrl

Overview:
Sequences every data-memory access from the EX/MEM boundary onto a split-transaction SRAM bus (req/addr_ok/data_ok). It holds one outstanding access at a time. It asserts a stall request to the pipeline controller until the access completes, and buffers the raw read word for the MEM stage, which performs byte/half extraction and extension. It also generates write strobes and replicated write data, detects misalignment, and drains accesses cancelled by flush.

Parameters:
ADDR_W, 32, byte address width
DATA_W, 32, data bus width (fixed 32; strobe logic assumes 4 byte lanes)

Ports:
clk  in  1  clock; all state changes on posedge
rst  in  1  synchronous, active-high reset
flush  in  1  cancel in-flight/pending access
req_valid  in  1  EX presents a memory access
req_wr  in  1  1=store, 0=load
req_size  in  2  0=byte, 1=half, 2=word, 3=reserved (treated as misaligned)
req_addr  in  ADDR_W  byte address
req_wdata  in  DATA_W  store data, right-aligned
req_ready  out  1  controller can accept a request this cycle
stallreq  out  1  stall request to pipeline controller
data_sram_req  out  1  bus request
data_sram_wr  out  1  bus write
data_sram_size  out  2  copy of req_size
data_sram_addr  out  ADDR_W  copy of req_addr
data_sram_wstrb  out  4  byte enables (0 for loads)
data_sram_wdata  out  DATA_W  lane-replicated store data
data_sram_addr_ok  in  1  request accepted by bus
data_sram_data_ok  in  1  data returned / write done
data_sram_rdata  in  DATA_W  read word
resp_valid  out  1  response held for MEM stage
resp_ready  in  1  MEM stage consumes response (not stalled)
resp_err  out  1  misaligned access, no bus traffic issued
resp_rdata  out  DATA_W  raw captured read word (0 for writes/errors)

Behaviour:
- States: IDLE, ADDR, DATA, RESP. Register `drop` marks a flushed access still on the bus.
- Reset: state=IDLE, drop=0, all registered outputs 0. req_ready=1 after reset. Reset mid-transaction abandons the bus access; no data_ok is expected afterwards.
- req_ready = (state==IDLE) && !flush.
- Alignment check:
  - size 0 is always aligned.
  - size 1 requires addr[0]=0.
  - size 2 requires addr[1:0]=0.
  - size 3 is always misaligned.
- IDLE:
  - If flush: stay in IDLE and ignore req_valid.
  - If req_valid and aligned: latch request fields and go to ADDR next cycle.
  - If req_valid and misaligned: go to RESP with resp_err=1 and resp_rdata=0. No bus request is issued.
- Strobes:
  - byte: 4'b0001 << addr[1:0].
  - half: 4'b0011 << addr[1:0].
  - word: 4'b1111.
  - load: 4'b0000.
- wdata replication: byte {4{wdata[7:0]}}, half {2{wdata[15:0]}}, word unchanged.
- ADDR:
  - data_sram_req=1. addr, size, wr, wstrb and wdata are held stable until addr_ok.
  - addr_ok=1: go to DATA with drop=flush.
  - addr_ok=0 and flush=1: go to IDLE; the request is withdrawn.
- DATA:
  - data_sram_req=0. flush sets drop.
  - data_ok=1 and drop=0: capture rdata (loads) or 0 (stores) into resp_rdata, then go to RESP.
  - data_ok=1 and drop=1: go to IDLE and clear drop.
  - data_ok in the same cycle as addr_ok is not legal on the bus and is ignored.
- RESP:
  - resp_valid=1.
  - resp_ready=1 or flush=1: go to IDLE and clear resp_valid/resp_err.
  - Otherwise hold resp_rdata/resp_err indefinitely.
- stallreq (combinational):
  - high in IDLE when req_valid && aligned && !flush;
  - high in ADDR and DATA when drop=0;
  - high in any state when req_valid && !req_ready && !flush;
  - low otherwise.
- Minimum load latency: accept at T; req at T+1; addr_ok at T+1; data_ok at T+2; resp_valid at T+3.
- Max one outstanding access. A new request cannot be accepted in the cycle RESP is consumed; it is accepted the following cycle.

Test Plan:
- Word load: req addr=0x100, size=2, wr=0 at T; addr_ok at T+1, data_ok with rdata=0xDEADBEEF at T+2 -> data_sram_req only at T+1, wstrb=0, resp_valid=1 and resp_rdata=0xDEADBEEF at T+3, stallreq high T..T+2.
- Byte store: addr=0x203, size=0, wdata=0x000000A5 -> wstrb=4'b1000, data_sram_wdata=0xA5A5A5A5; half store addr=0x202 wdata=0x1234 -> wstrb=4'b1100, wdata=0x12341234.
- Misaligned: half at 0x301 and word at 0x302 -> no data_sram_req, resp_valid=1, resp_err=1, resp_rdata=0 next cycle, stallreq low.
- Bus backpressure: addr_ok held 0 for 5 cycles -> addr/wstrb/wdata stable, req high all 5 cycles; resp_ready low 3 cycles in RESP -> resp_rdata held, no new accept until consumed.
- Flush: flush in ADDR without addr_ok -> IDLE next cycle, no data_ok awaited; flush in DATA -> later data_ok (rdata=0x55) produces no resp_valid, req_ready returns 1 the cycle after data_ok.
- Reset in DATA state -> next cycle state IDLE, all outputs 0, req_ready=1; subsequent word load completes normally.
